ps2_receiver: RTL and testbench

- Receives device-to-host frames from a PS/2 keyboard on the board's ps2_clk/ps2_data lines.
- Decodes the frames into scan codes, with make/break and extended-prefix flags.
- Feeds game logic such as the `ingame`/`score` producers that drive the VGA display.
- Receive-only: never drives the PS/2 lines; the top level ties the inout pads to these inputs.

---
 rtl/ps2_receiver_if.sv | 19 +
 rtl/ps2_receiver.sv | 167 ++++++++++++++++
 tb/tb_ps2_receiver.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_receiver_if.sv
// Decoded-keyboard output bundle of ps2_receiver.
// The receiver drives it through the master modport; consumers read it through slave.
`timescale 1ns/1ps
interface ps2_receiver_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_err;
  logic       busy;

  modport master (
    output scan_code, scan_valid, is_break, is_extended, frame_err, busy
  );

  modport slave (
    input scan_code, scan_valid, is_break, is_extended, frame_err, busy
  );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the PS/2 lines, then
// decodes 11-bit frames into scan codes with break (F0) and extended (E0) flags.
`timescale 1ns/1ps
module ps2_receiver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_receiver_if.master kbd
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic                   filt_clk_q, filt_clk_d, filt_prev_q, filt_prev_d;
  logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_ok_q, par_ok_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   brk_q, brk_d, ext_q, ext_d;
  logic [7:0]             scan_code_q, scan_code_d;
  logic                   scan_valid_q, scan_valid_d;
  logic                   is_break_q, is_break_d, is_ext_q, is_ext_d;
  logic                   frame_err_q, frame_err_d;
  logic                   clk_s, data_s, fe;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fe     = filt_prev_q & ~filt_clk_q;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    filt_prev_d = filt_clk_q;
    filt_clk_d  = filt_clk_q;
    // Count consecutive samples that disagree with the filtered level.
    if (clk_s == filt_clk_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      filt_clk_d = clk_s;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_ok_d     = par_ok_q;
    tmo_d        = tmo_q;
    brk_d        = brk_q;
    ext_d        = ext_q;
    scan_code_d  = scan_code_q;
    is_break_d   = is_break_q;
    is_ext_d     = is_ext_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fe) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: if (!data_s) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d = {data_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = PARITY;
          else                   bit_cnt_d = bit_cnt_q + 1'b1;
        end
        PARITY: begin
          par_ok_d = ^{shift_q, data_s};
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (par_ok_q && data_s) begin
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              scan_code_d  = shift_q;
              is_break_d   = brk_q;
              is_ext_d     = ext_q;
              scan_valid_d = 1'b1;
              brk_d        = 1'b0;
              ext_d        = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            brk_d       = 1'b0;
            ext_d       = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      brk_d       = 1'b0;
      ext_d       = 1'b0;
      tmo_d       = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Synchronizer and filter preload high so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      filt_clk_q   <= 1'b1;
      filt_prev_q  <= 1'b1;
      filt_cnt_q   <= '0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      tmo_q        <= '0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      is_break_q   <= 1'b0;
      is_ext_q     <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      filt_clk_q   <= filt_clk_d;
      filt_prev_q  <= filt_prev_d;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      tmo_q        <= tmo_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      is_break_q   <= is_break_d;
      is_ext_q     <= is_ext_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign kbd.scan_code   = scan_code_q;
  assign kbd.scan_valid  = scan_valid_q;
  assign kbd.is_break    = is_break_q;
  assign kbd.is_extended = is_ext_q;
  assign kbd.frame_err   = frame_err_q;
  assign kbd.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: frames are built from bytes, and a frame-level model
// predicts the ordered stream of decoded codes and errors the receiver must emit.
`timescale 1ns/1ps
module tb_ps2_receiver;
  localparam int unsigned HALF = 40;
  localparam int unsigned TMO  = 2000;

  logic clk = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  ps2_receiver_if kbd ();

  ps2_receiver #(.SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .kbd(kbd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         brk;
    bit         ext;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        cur;
  bit         m_brk = 1'b0, m_ext = 1'b0;
  logic [7:0] hold_code = '0;
  bit         hold_brk = 1'b0, hold_ext = 1'b0;
  bit         sv_prev = 1'b0, fe_prev = 1'b0;
  int unsigned vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: what a complete frame must produce, from the byte rules alone.
  task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    ev_t e;
    if (par_bad || stop_bad) begin
      e = '{1'b1, 8'h00, 1'b0, 1'b0};
      exp_q.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      e = '{1'b0, b, m_brk, m_ext};
      exp_q.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                            input int unsigned nbits, input bit glitch);
    logic [10:0] f;
    f = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) begin
      if (i == 2) chk("busy_mid", kbd.busy, 1);
      ps2_data = f[i];
      if (glitch && i == 5) begin
        wait_cyc(10); ps2_clk = 1'b0; wait_cyc(4); ps2_clk = 1'b1; wait_cyc(HALF - 14);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    model_frame(b, par_bad, stop_bad);
    send_frame(b, par_bad, stop_bad, 11, 1'b0);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      wait_cyc(1);
      n++;
    end
    wait_cyc(5);
    chk("drain", exp_q.size(), 0);
    chk("busy_idle", kbd.busy, 0);
  endtask

  task automatic chk_out(input string name, input logic [7:0] code, input bit brk, input bit ext);
    chk({name, "_code"}, kbd.scan_code, code);
    chk({name, "_brk"}, kbd.is_break, brk);
    chk({name, "_ext"}, kbd.is_extended, ext);
  endtask

  task automatic do_reset(input int unsigned n);
    reset     = 1'b0;
    m_brk     = 1'b0;
    m_ext     = 1'b0;
    hold_code = '0;
    hold_brk  = 1'b0;
    hold_ext  = 1'b0;
    exp_q.delete();
    wait_cyc(n);
    chk("rst_valid", kbd.scan_valid, 0);
    chk("rst_err", kbd.frame_err, 0);
    chk("rst_busy", kbd.busy, 0);
    chk_out("rst", 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    wait_cyc(5);
  endtask

  // Every cycle: any pulse must match the next predicted event; held outputs track the model.
  always @(negedge clk) begin
    chk("pulse_overlap", kbd.scan_valid & kbd.frame_err, 0);
    chk("sv_width", sv_prev & kbd.scan_valid, 0);
    chk("fe_width", fe_prev & kbd.frame_err, 0);
    if (kbd.scan_valid || kbd.frame_err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {kbd.scan_valid, kbd.frame_err}, 0);
      end else begin
        cur = exp_q.pop_front();
        chk("event_kind", kbd.frame_err, cur.is_err);
        if (!cur.is_err) begin
          hold_code = cur.code;
          hold_brk  = cur.brk;
          hold_ext  = cur.ext;
        end
      end
    end
    chk("scan_code", kbd.scan_code, hold_code);
    chk("is_break", kbd.is_break, hold_brk);
    chk("is_extended", kbd.is_extended, hold_ext);
    sv_prev = kbd.scan_valid;
    fe_prev = kbd.frame_err;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int unsigned r;
    wait_cyc(3);
    do_reset(5);

    frame(8'h1C, 0, 0); drain(); chk_out("make1c", 8'h1C, 0, 0);
    frame(8'hF0, 0, 0); frame(8'h1C, 0, 0); drain(); chk_out("brk1c", 8'h1C, 1, 0);
    frame(8'hE0, 0, 0); frame(8'hF0, 0, 0); frame(8'h75, 0, 0); drain();
    chk_out("extbrk75", 8'h75, 1, 1);
    frame(8'h75, 0, 0); drain(); chk_out("make75", 8'h75, 0, 0);

    frame(8'h1C, 1, 0); drain(); chk_out("parerr_hold", 8'h75, 0, 0);
    frame(8'h1C, 0, 0); drain(); chk_out("after_parerr", 8'h1C, 0, 0);
    frame(8'hF0, 0, 0); frame(8'h33, 0, 1); frame(8'h33, 0, 0); drain();
    chk_out("stoperr_clears", 8'h33, 0, 0);

    // Partial frame then silence: expect a timeout error, not an early one.
    model_frame(8'h00, 1, 0);
    send_frame(8'h5B, 0, 0, 5, 0);
    chk("busy_before_tmo", kbd.busy, 1);
    wait_cyc(TMO - 300);
    chk("no_early_tmo", exp_q.size(), 1);
    chk("busy_pre_tmo", kbd.busy, 1);
    wait_cyc(500);
    drain();
    frame(8'h29, 0, 0); drain(); chk_out("after_tmo", 8'h29, 0, 0);

    // Short ps2_clk glitches, idle (with data low) and mid-frame.
    ps2_data = 1'b0; wait_cyc(20);
    ps2_clk = 1'b0; wait_cyc(5); ps2_clk = 1'b1; wait_cyc(30);
    chk("glitch_idle_busy", kbd.busy, 0);
    ps2_data = 1'b1; wait_cyc(HALF);
    model_frame(8'h5A, 0, 0);
    send_frame(8'h5A, 0, 0, 11, 1);
    drain(); chk_out("glitch_mid", 8'h5A, 0, 0);

    // Reset mid-frame after 3 data bits, then a full frame.
    frame(8'hE0, 0, 0);
    send_frame(8'hAA, 0, 0, 4, 0);
    do_reset(10);
    frame(8'h1C, 0, 0); drain(); chk_out("after_rst", 8'h1C, 0, 0);

    for (int unsigned k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      b = (r < 2) ? 8'hE0 : (r == 2) ? 8'hF0 : 8'($urandom);
      r = $urandom_range(0, 11);
      frame(b, r == 0, r == 1);
      wait_cyc($urandom_range(5, 100));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
